bird_sprite_ctrl: RTL and testbench

Sequences reads of the 24×24 bird sprite ROM in step with the VGA pixel scan. Each frame it latches the bird's top-left position and decides, per scan pixel, whether that pixel falls inside the sprite box. For in-box pixels it drives the ROM row/column address, realigns the ROM's one-cycle read latency, and presents a registered colour plus an opaque flag to the pixel mux. It also counts the opaque bird pixels drawn each frame for collision and debug logic.

---
 rtl/bird_sprite_ctrl_if.sv | 30 +++
 rtl/bird_sprite_ctrl.sv | 85 ++++++++
 tb/tb_bird_sprite_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bird_sprite_ctrl_if.sv
// Scan, ROM and colour-output signals of the bird sprite controller.
// The DUT takes the slave side; the scan generator/pixel mux the master side.
interface bird_sprite_ctrl_if;
    logic        frame_start;
    logic [9:0]  bird_x;
    logic [9:0]  bird_y;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [4:0]  rom_row;
    logic [4:0]  rom_col;
    logic [11:0] rom_pixel;
    logic [11:0] rgb_out;
    logic        rgb_valid;
    logic [9:0]  frame_pixels;

    modport master (
        output frame_start, bird_x, bird_y,
        output pix_valid, pix_x, pix_y, rom_pixel,
        input  rom_row, rom_col,
        input  rgb_out, rgb_valid, frame_pixels
    );

    modport slave (
        input  frame_start, bird_x, bird_y,
        input  pix_valid, pix_x, pix_y, rom_pixel,
        output rom_row, rom_col,
        output rgb_out, rgb_valid, frame_pixels
    );
endinterface

// File: rtl/bird_sprite_ctrl.sv
// Bird sprite ROM sequencer: box test, ROM addressing, 2-cycle colour pipe.
// Optional BIRD_KEY_EN: treat KEY_COLOR ROM pixels as transparent.
module bird_sprite_ctrl #(
    parameter int          SPRITE_W  = 24,
    parameter int          SPRITE_H  = 24,
    parameter logic [11:0] KEY_COLOR = 12'hF0F
) (
    input logic               clk,
    input logic               reset,
    bird_sprite_ctrl_if.slave bus
);

    logic [9:0]  lat_x;
    logic [9:0]  lat_y;
    logic        v1;
    logic        v2;
    logic [9:0]  cnt;
    logic [9:0]  cnt_next;
    logic [10:0] x_end;
    logic [10:0] y_end;
    logic        in_box;
    logic        opaque;
    logic [4:0]  dx;
    logic [4:0]  dy;

    // 11-bit box ends so a sprite near column/row 1023 clips instead of wrapping
    assign x_end = {1'b0, lat_x} + 11'(SPRITE_W);
    assign y_end = {1'b0, lat_y} + 11'(SPRITE_H);

    assign in_box = bus.pix_valid
                 && (bus.pix_x >= lat_x)
                 && ({1'b0, bus.pix_x} < x_end)
                 && (bus.pix_y >= lat_y)
                 && ({1'b0, bus.pix_y} < y_end);

    assign dx = 5'(bus.pix_x - lat_x);
    assign dy = 5'(bus.pix_y - lat_y);

`ifdef BIRD_KEY_EN
    assign opaque = v2 && (bus.rom_pixel != KEY_COLOR);
`else
    assign opaque = v2;
`endif

    assign cnt_next = (opaque && (cnt != 10'd1023)) ? cnt + 10'd1 : cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_x            <= '0;
            lat_y            <= '0;
            v1               <= 1'b0;
            v2               <= 1'b0;
            bus.rom_row      <= '0;
            bus.rom_col      <= '0;
            bus.rgb_out      <= '0;
            bus.rgb_valid    <= 1'b0;
            cnt              <= '0;
            bus.frame_pixels <= '0;
        end else begin
            if (bus.frame_start) begin
                lat_x <= bus.bird_x;
                lat_y <= bus.bird_y;
            end

            v1 <= in_box;
            if (in_box) begin
                bus.rom_row <= dy;
                bus.rom_col <= dx;
            end

            v2            <= v1;
            bus.rgb_out   <= opaque ? bus.rom_pixel : 12'h000;
            bus.rgb_valid <= opaque;

            // a pixel landing on the frame_start edge still belongs to the old frame
            if (bus.frame_start) begin
                bus.frame_pixels <= cnt_next;
                cnt              <= '0;
            end else begin
                cnt <= cnt_next;
            end
        end
    end

endmodule

// File: tb/tb_bird_sprite_ctrl.sv
// Directed bench for bird_sprite_ctrl with a synchronous sprite ROM model.
// Expected values come from the bench's own box geometry and ROM pattern.
module tb_bird_sprite_ctrl;

    logic clk;
    logic reset;
    bird_sprite_ctrl_if bus ();

    bird_sprite_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int rom_mode = 0;
    logic [11:0] rom_q = 12'h000;

    function automatic logic [11:0] romf(int mode, int r, int c);
        logic [4:0] r5;
        logic [4:0] c5;
        r5 = r[4:0];
        c5 = c[4:0];
        case (mode)
            1:       return {2'b10, r5, c5};
            2:       return (r == 0) ? 12'hF0F : 12'hFF0;
            default: return 12'hFF0;
        endcase
    endfunction

    always @(posedge clk)
        rom_q <= romf(rom_mode, int'(bus.rom_row), int'(bus.rom_col));
    assign bus.rom_pixel = rom_q;

    int ebx = 0;
    int eby = 0;
    bit chk_en = 0;

    function automatic bit exp_in(int x, int y);
        return x >= ebx && x < ebx + 24 && y >= eby && y < eby + 24;
    endfunction

    function automatic bit exp_op(int x, int y);
        bit r;
        r = exp_in(x, y);
`ifdef BIRD_KEY_EN
        if (r && romf(rom_mode, y - eby, x - ebx) == 12'hF0F) r = 0;
`endif
        return r;
    endfunction

    bit h1v, h2v;
    int h1x, h1y, h2x, h2y;
    int hits, bad_col, outside, missed, addr_err, low_hits, row0_hits;
    int first_x, first_y, last_x, last_y;

    task automatic clear_stats();
        h1v = 0; h2v = 0;
        h1x = 0; h1y = 0; h2x = 0; h2y = 0;
        hits = 0; bad_col = 0; outside = 0; missed = 0;
        addr_err = 0; low_hits = 0; row0_hits = 0;
        first_x = -1; first_y = -1; last_x = -1; last_y = -1;
    endtask

    task automatic cycle(input logic f, input logic v, input int x, input int y);
        bus.frame_start = f;
        bus.pix_valid   = v;
        bus.pix_x       = x[9:0];
        bus.pix_y       = y[9:0];
        @(posedge clk);
        #1;
        if (chk_en && v && exp_in(x, y))
            if (int'(bus.rom_row) != y - eby || int'(bus.rom_col) != x - ebx)
                addr_err++;
        if (bus.rgb_valid) begin
            hits++;
            if (first_x < 0) begin
                first_x = h2x;
                first_y = h2y;
            end
            last_x = h2x;
            last_y = h2y;
            if (h2x < 24 || h2y < 24) low_hits++;
            if (h2y == eby) row0_hits++;
            if (chk_en && !(h2v && exp_op(h2x, h2y))) outside++;
            if (chk_en && bus.rgb_out !== romf(rom_mode, h2y - eby, h2x - ebx))
                bad_col++;
        end else begin
            if (bus.rgb_out !== 12'h000) bad_col++;
            if (chk_en && h2v && exp_op(h2x, h2y)) missed++;
        end
        h2v = h1v; h2x = h1x; h2y = h1y;
        h1v = v;   h1x = x;   h1y = y;
    endtask

    task automatic scan(input int x0, input int x1, input int y0, input int y1);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                cycle(1'b0, 1'b1, x, y);
        cycle(1'b0, 1'b0, 0, 0);
        cycle(1'b0, 1'b0, 0, 0);
    endtask

    task automatic new_frame(input int bx, input int by);
        bus.bird_x = bx[9:0];
        bus.bird_y = by[9:0];
        cycle(1'b1, 1'b0, 0, 0);
    endtask

    task automatic check_scan(input string tag, input int exp_hits);
        checks++;
        if (hits !== exp_hits) begin
            errors++;
            $display("FAIL %s hits: got %0d want %0d", tag, hits, exp_hits);
        end
        checks++;
        if (outside !== 0 || missed !== 0) begin
            errors++;
            $display("FAIL %s coverage: outside %0d missed %0d want 0/0",
                     tag, outside, missed);
        end
        checks++;
        if (bad_col !== 0 || addr_err !== 0) begin
            errors++;
            $display("FAIL %s data: bad colour %0d bad addr %0d want 0/0",
                     tag, bad_col, addr_err);
        end
    endtask

    task automatic check_fp(input string tag, input int exp_fp);
        checks++;
        if (int'(bus.frame_pixels) !== exp_fp) begin
            errors++;
            $display("FAIL %s frame_pixels: got %0d want %0d",
                     tag, bus.frame_pixels, exp_fp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.rgb_valid !== 1'b0 || bus.rgb_out !== 12'h000) begin
            errors++;
            $display("FAIL reset_rgb: got %b/%h want 0/000", bus.rgb_valid, bus.rgb_out);
        end
        checks++;
        if (bus.rom_row !== 5'd0 || bus.rom_col !== 5'd0) begin
            errors++;
            $display("FAIL reset_addr: got %0d/%0d want 0/0", bus.rom_row, bus.rom_col);
        end
        check_fp("reset", 0);
        reset = 1'b0;
        rom_mode = 1;
        chk_en = 0;
        new_frame(100, 200);
        cycle(1'b0, 1'b1, 100, 200);
        cycle(1'b0, 1'b1, 101, 200);
        cycle(1'b0, 1'b1, 102, 200);
        checks++;
        if (bus.rgb_valid !== 1'b1 || bus.rom_col !== 5'd2) begin
            errors++;
            $display("FAIL pre_reset: valid %b col %0d want 1/2", bus.rgb_valid, bus.rom_col);
        end
        bus.pix_x = 10'd103;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.rgb_valid !== 1'b0 || bus.rgb_out !== 12'h000
            || bus.rom_row !== 5'd0 || bus.rom_col !== 5'd0) begin
            errors++;
            $display("FAIL async_reset: valid %b rgb %h row %0d col %0d want all 0",
                     bus.rgb_valid, bus.rgb_out, bus.rom_row, bus.rom_col);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        new_frame(100, 200);
        cycle(1'b0, 1'b1, 105, 200);
        checks++;
        if (bus.rom_row !== 5'd0 || bus.rom_col !== 5'd5 || bus.rgb_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_k: row %0d col %0d valid %b want 0/5/0",
                     bus.rom_row, bus.rom_col, bus.rgb_valid);
        end
        cycle(1'b0, 1'b0, 0, 0);
        checks++;
        if (bus.rgb_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_k1: valid %b want 0", bus.rgb_valid);
        end
        cycle(1'b0, 1'b0, 0, 0);
        checks++;
        if (bus.rgb_valid !== 1'b1 || bus.rgb_out !== 12'h805) begin
            errors++;
            $display("FAIL post_reset_k2: valid %b rgb %h want 1/805",
                     bus.rgb_valid, bus.rgb_out);
        end
        cycle(1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_full_draw();
        rom_mode = 0;
        ebx = 100; eby = 200;
        chk_en = 1;
        new_frame(100, 200);
        clear_stats();
        scan(90, 130, 190, 230);
        check_scan("full", 576);
        checks++;
        if (first_x !== 100 || first_y !== 200 || last_x !== 123 || last_y !== 223) begin
            errors++;
            $display("FAIL full_ends: first (%0d,%0d) last (%0d,%0d) want (100,200) (123,223)",
                     first_x, first_y, last_x, last_y);
        end
        new_frame(100, 200);
        check_fp("full", 576);
    endtask

    task automatic test_latch_isolation();
        rom_mode = 1;
        ebx = 100; eby = 200;
        chk_en = 1;
        new_frame(100, 200);
        clear_stats();
        scan(90, 130, 190, 205);
        bus.bird_x = 10'd300;
        scan(90, 130, 206, 230);
        check_scan("latch_hold", 576);
        new_frame(300, 200);
        check_fp("latch_hold", 576);
        ebx = 300;
        clear_stats();
        scan(290, 330, 190, 230);
        check_scan("latch_move", 576);
        checks++;
        if (first_x !== 300 || first_y !== 200) begin
            errors++;
            $display("FAIL latch_move_first: got (%0d,%0d) want (300,200)", first_x, first_y);
        end
        new_frame(300, 200);
        check_fp("latch_move", 576);
    endtask

    task automatic test_edge_clip();
        rom_mode = 1;
        ebx = 1010; eby = 1010;
        chk_en = 1;
        new_frame(1010, 1010);
        clear_stats();
        scan(0, 30, 0, 30);
        scan(1000, 1023, 0, 30);
        scan(0, 30, 1000, 1023);
        scan(1000, 1023, 1000, 1023);
        check_scan("clip", 196);
        checks++;
        if (low_hits !== 0) begin
            errors++;
            $display("FAIL clip_wrap: got %0d low hits want 0", low_hits);
        end
        new_frame(1010, 1010);
        check_fp("clip", 196);
    endtask

    task automatic test_color_key();
        int exp_fp;
        int exp_row0;
`ifdef BIRD_KEY_EN
        exp_fp = 552;
        exp_row0 = 0;
`else
        exp_fp = 576;
        exp_row0 = 24;
`endif
        rom_mode = 2;
        ebx = 100; eby = 200;
        chk_en = 1;
        new_frame(100, 200);
        clear_stats();
        scan(95, 128, 195, 228);
        check_scan("key", exp_fp);
        checks++;
        if (row0_hits !== exp_row0) begin
            errors++;
            $display("FAIL key_row0: got %0d want %0d", row0_hits, exp_row0);
        end
        new_frame(100, 200);
        check_fp("key", exp_fp);
    endtask

    task automatic test_simultaneous();
        rom_mode = 0;
        chk_en = 0;
        new_frame(100, 200);
        cycle(1'b0, 1'b1, 100, 200);
        cycle(1'b0, 1'b1, 101, 200);
        bus.bird_x = 10'd500;
        cycle(1'b1, 1'b1, 102, 200);
        check_fp("simul_edge", 1);
        cycle(1'b0, 1'b1, 103, 200);
        checks++;
        if (bus.rom_col !== 5'd2) begin
            errors++;
            $display("FAIL simul_hold_col: got %0d want 2", bus.rom_col);
        end
        repeat (3) cycle(1'b0, 1'b0, 0, 0);
        new_frame(500, 200);
        check_fp("simul_next", 2);
    endtask

    initial begin
        reset = 1'b1;
        bus.frame_start = 1'b0;
        bus.bird_x = '0;
        bus.bird_y = '0;
        bus.pix_valid = 1'b0;
        bus.pix_x = '0;
        bus.pix_y = '0;
        clear_stats();
        test_reset();
        test_full_draw();
        test_latch_isolation();
        test_edge_clip();
        test_color_key();
        test_simultaneous();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
